// File: rtl/mult_serial_mac.sv
// Sequential radix-4 shift-add multiply-accumulate with valid/ready operand and result handshakes.
// Optional build macro: SIGNED_MULT_EN (two's complement operands, top multiplier pair weighted -2/+1).
module mult_serial_mac #(
  parameter int N     = 8,
  parameter int M     = 8,
  parameter int ACC_W = N + M + 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       A,
  input  logic [M-1:0]       X,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N+M-1:0]     AX,
  output logic [ACC_W-1:0]   ACC
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CNT_W = (M > 2) ? $clog2(M / 2) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M / 2 - 1);

  state_t            state_r;
  state_t            state_nx_s;
  logic [N-1:0]      a_r;
  logic [M-1:0]      x_r;
  logic              clr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [N+M-1:0]    p_r;
  logic [N+M-1:0]    p_next_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [N+M-1:0]    ax_r;
  logic [ACC_W-1:0]  acc_r;
  logic              last_s;
  logic [2:0]        dig_s;
  logic [N+1:0]      a_ext_s;
  logic [N+1:0]      hi_s;
  logic [N+1:0]      sum_s;
  logic [ACC_W-1:0]  p_ext_s;

  // Radix-4 digit multiple of A; digits 3'b110/3'b111 (-2/-1) only occur for a signed top pair.
  function automatic logic [N+1:0] digit_multiple(input logic [N+1:0] a_ext, input logic [2:0] dig);
    logic [N+1:0] res;
    case (dig)
      3'b000:  res = {(N+2){1'b0}};
      3'b001:  res = a_ext;
      3'b010:  res = a_ext << 1;
      3'b011:  res = a_ext + (a_ext << 1);
      3'b110:  res = {(N+2){1'b0}} - (a_ext << 1);
      3'b111:  res = {(N+2){1'b0}} - a_ext;
      default: res = {(N+2){1'b0}};
    endcase
    return res;
  endfunction

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign AX        = ax_r;
  assign ACC       = acc_r;
  assign last_s    = (cnt_r == CNT_LAST);

  // Step adder: only the top N bits of P meet the new digit product; lower bits just shift down.
  always_comb begin
    dig_s = {1'b0, x_r[1:0]};
`ifdef SIGNED_MULT_EN
    a_ext_s = {{2{a_r[N-1]}}, a_r};
    hi_s    = {{2{p_r[N+M-1]}}, p_r[N+M-1:M]};
    if (last_s) begin
      dig_s = {x_r[1], x_r[1:0]};
    end else begin
      dig_s = {1'b0, x_r[1:0]};
    end
`else
    a_ext_s = {2'b00, a_r};
    hi_s    = {2'b00, p_r[N+M-1:M]};
`endif
    sum_s = hi_s + digit_multiple(a_ext_s, dig_s);
  end

  if (M > 2) begin : g_shift
    assign p_next_s = {sum_s, p_r[M-1:2]};
  end else begin : g_single
    assign p_next_s = sum_s;
  end

`ifdef SIGNED_MULT_EN
  assign p_ext_s = ACC_W'($signed(p_r));
`else
  assign p_ext_s = ACC_W'(p_r);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s = MULT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MULT: begin
        if (last_s) begin
          state_nx_s = FIN;
        end else begin
          state_nx_s = MULT;
        end
      end
      FIN:  state_nx_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Operand capture, shift-add steps and result/handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= {N{1'b0}};
      x_r         <= {M{1'b0}};
      clr_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      p_r         <= {(N+M){1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      ax_r        <= {(N+M){1'b0}};
      acc_r       <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= A;
            x_r        <= X;
            clr_r      <= acc_clr;
            cnt_r      <= {CNT_W{1'b0}};
            p_r        <= {(N+M){1'b0}};
            in_ready_r <= 1'b0;
          end
        end
        MULT: begin
          p_r   <= p_next_s;
          x_r   <= x_r >> 2;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        FIN: begin
          ax_r        <= p_r;
          acc_r       <= clr_r ? p_ext_s : (acc_r + p_ext_s);
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_serial_mac.sv
// Scoreboard bench for mult_serial_mac: stimulus pushes reference results, a monitor pops and compares.
// Honours SIGNED_MULT_EN in its reference model and in its directed constant checks.
module tb_mult_serial_mac;

  localparam int N     = 8;
  localparam int M     = 8;
  localparam int ACC_W = N + M + 4;
  localparam int LAT   = M / 2 + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     A;
  logic [M-1:0]     X;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [N+M-1:0]   AX;
  logic [ACC_W-1:0] ACC;

  typedef struct {
    logic [N+M-1:0]   ax;
    logic [ACC_W-1:0] acc;
    int               t;
  } exp_t;

  exp_t             exp_q[$];
  logic [ACC_W-1:0] acc_model;
  int               n_cmp  = 0;
  int               n_fail = 0;
  int               cyc    = 0;
  logic             ov_prev = 1'b0;
  logic             rnd_ready = 1'b0;

  mult_serial_mac #(.N(N), .M(M), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .X(X), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .AX(AX), .ACC(ACC)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer product, accumulator kept modulo 2^ACC_W.
  task automatic model_push(input logic [N-1:0] a, input logic [M-1:0] x, input logic clr, input int t);
    longint     prod;
    logic [63:0] pv;
    exp_t       e;
`ifdef SIGNED_MULT_EN
    prod = longint'($signed(a)) * longint'($signed(x));
`else
    prod = longint'(a) * longint'(x);
`endif
    pv = prod;
    acc_model = clr ? pv[ACC_W-1:0] : acc_model + pv[ACC_W-1:0];
    e.ax  = pv[N+M-1:0];
    e.acc = acc_model;
    e.t   = t;
    exp_q.push_back(e);
  endtask

  // Present a beat at a negedge, hold it until accepted, record the expected result.
  task automatic send(input logic [N-1:0] a, input logic [M-1:0] x, input logic clr);
    int n;
    @(negedge clk);
    A = a; X = x; acc_clr = clr; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      model_push(a, x, clr, cyc);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: each new result is compared against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !ov_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("AX", 64'(AX), 64'(e.ax));
        chk("ACC", 64'(ACC), 64'(e.acc));
        chk("latency", 64'(cyc - e.t), 64'(LAT));
      end
    end
    ov_prev = out_valid;
  end

  always @(negedge clk) begin
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N+M-1:0]   ax_hold;
    logic [ACC_W-1:0] acc_hold;
    int n;
    rst = 1'b1; in_valid = 1'b0; A = '0; X = '0; acc_clr = 1'b0; out_ready = 1'b1;
    acc_model = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_AX", 64'(AX), 64'd0);
    chk("rst_ACC", 64'(ACC), 64'd0);
    rst = 1'b0;

    // Full-scale operands.
    send(8'hFF, 8'hFF, 1'b1);
    drain();
`ifndef SIGNED_MULT_EN
    chk("t1_AX", 64'(AX), 64'h0FE01);
    chk("t1_ACC", 64'(ACC), 64'h0FE01);
`else
    chk("t1_AX", 64'(AX), 64'h00001);
`endif

    // Back-to-back accumulation.
    send(8'd3, 8'd5, 1'b1);
    send(8'd10, 8'd10, 1'b0);
    send(8'd255, 8'd2, 1'b0);
    drain();
`ifndef SIGNED_MULT_EN
    chk("t2_AX", 64'(AX), 64'd510);
    chk("t2_ACC", 64'(ACC), 64'd625);
`endif

    // Consumer stall: result held, new operand refused.
    out_ready = 1'b0;
    send(8'd77, 8'd19, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t3_out_valid_seen", 64'(out_valid), 64'd1);
    ax_hold = AX; acc_hold = ACC;
    for (int i = 0; i < 7; i++) begin
      A = 8'($urandom); X = 8'($urandom); acc_clr = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("t3_hold_out_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_in_ready", 64'(in_ready), 64'd0);
      chk("t3_hold_AX", 64'(AX), 64'(ax_hold));
      chk("t3_hold_ACC", 64'(ACC), 64'(acc_hold));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_in_ready", 64'(in_ready), 64'd1);
    chk("t3_release_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("t3_no_stale_accept", 64'(in_ready), 64'd1);

    // Reset during the second MULT cycle discards the op and clears ACC.
    send(8'd9, 8'd9, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    acc_model = '0;
    @(negedge clk);
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_ACC", 64'(ACC), 64'd0);
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    send(8'd7, 8'd6, 1'b0);
    drain();
    chk("t4_ACC_after", 64'(ACC), 64'd42);

    // Accumulator wrap.
    for (int i = 0; i < 17; i++) send(8'd255, 8'd255, (i == 0));
    drain();
`ifndef SIGNED_MULT_EN
    chk("t5_ACC_wrap", 64'(ACC), 64'd56849);
`endif

`ifdef SIGNED_MULT_EN
    send(8'h80, 8'h7F, 1'b1);
    drain();
    chk("t6_AX", 64'(AX), 64'h0C080);
    send(8'hFF, 8'hFF, 1'b0);
    drain();
    chk("t6_AX2", 64'(AX), 64'h00001);
    chk("t6_ACC", 64'(ACC), 64'hFC081);
`endif

    // Random beats with random consumer back-pressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(8'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0));
    end
    drain();
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
